// File: rtl/ms_timer.sv
// ms_timer
//
// Counts millisecond ticks against a programmed period and raises a
// one-cycle expiry pulse when the period runs out. Runs either once
// (one-shot) or continuously with auto-reload (periodic). It is used for
// exposure windows, frame intervals and watchdog timeouts in the ToF
// control path.
//
// Ports:
//   clk_i           system clock
//   rst_ni          synchronous reset, active-low, sampled on posedge clk_i
//   tick_ms_i       one-cycle millisecond strobe
//   start_i         one-cycle request: latch period/mode and (re)start
//   stop_i          one-cycle request: abort and return to IDLE
//   periodic_i      1 = auto-reload on expiry, 0 = one-shot (sampled with start)
//   period_ms_i     period in ms (sampled with start)
//   busy_o          high while counting
//   expired_o       one-cycle pulse on each expiry
//   remaining_ms_o  ticks left in the current period
//   elapsed_ms_o    ticks since the last start, wraps
//   expire_cnt_o    expiries since the last start, wraps
//   err_o           sticky: start issued with a zero period
//
// Every output comes straight from a flop; nothing passes combinationally
// from an input to an output.

module ms_timer #(
  parameter int PERIOD_W = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tick_ms_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                periodic_i,
  input  logic [PERIOD_W-1:0] period_ms_i,
  output logic                busy_o,
  output logic                expired_o,
  output logic [PERIOD_W-1:0] remaining_ms_o,
  output logic [PERIOD_W-1:0] elapsed_ms_o,
  output logic [CNT_W-1:0]    expire_cnt_o,
  output logic                err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                expired_q, expired_d;
  logic                periodic_q, periodic_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] remaining_q, remaining_d;
  logic [PERIOD_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0]    expire_cnt_q, expire_cnt_d;
  logic                err_q, err_d;

  // Next-state logic. The if/else chain encodes the per-cycle priority
  // stop > start > tick; reset is applied on top of this in the flop block.
  // A tick coinciding with start or stop falls through untaken, which is
  // how the coincident tick gets discarded.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    expired_d    = 1'b0;
    periodic_d   = periodic_q;
    period_d     = period_q;
    remaining_d  = remaining_q;
    elapsed_d    = elapsed_q;
    expire_cnt_d = expire_cnt_q;
    err_d        = err_q;

    if (stop_i) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else if (start_i) begin
      if (period_ms_i == '0) begin
        // A zero period can never expire; refuse it and flag the error
        // while leaving the counters showing their last values.
        state_d = IDLE;
        busy_d  = 1'b0;
        err_d   = 1'b1;
      end else begin
        state_d      = RUN;
        busy_d       = 1'b1;
        periodic_d   = periodic_i;
        period_d     = period_ms_i;
        remaining_d  = period_ms_i;
        elapsed_d    = '0;
        expire_cnt_d = '0;
        err_d        = 1'b0;
      end
    end else if (tick_ms_i && (state_q == RUN)) begin
      elapsed_d = elapsed_q + PERIOD_W'(1);
      // remaining is never 0 in RUN, so ==1 is the last tick of a period.
      if (remaining_q == PERIOD_W'(1)) begin
        expired_d    = 1'b1;
        expire_cnt_d = expire_cnt_q + CNT_W'(1);
        if (periodic_q) begin
          // Reload directly so the next period is exactly period ticks.
          remaining_d = period_q;
        end else begin
          remaining_d = '0;
          state_d     = IDLE;
          busy_d      = 1'b0;
        end
      end else begin
        remaining_d = remaining_q - PERIOD_W'(1);
      end
    end
  end

  // State and output registers, cleared by the synchronous active-low
  // reset. Reset mid-run simply drops everything, with no expiry pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      expired_q    <= 1'b0;
      periodic_q   <= 1'b0;
      period_q     <= '0;
      remaining_q  <= '0;
      elapsed_q    <= '0;
      expire_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      expired_q    <= expired_d;
      periodic_q   <= periodic_d;
      period_q     <= period_d;
      remaining_q  <= remaining_d;
      elapsed_q    <= elapsed_d;
      expire_cnt_q <= expire_cnt_d;
      err_q        <= err_d;
    end
  end

  assign busy_o         = busy_q;
  assign expired_o      = expired_q;
  assign remaining_ms_o = remaining_q;
  assign elapsed_ms_o   = elapsed_q;
  assign expire_cnt_o   = expire_cnt_q;
  assign err_o          = err_q;

endmodule

// File: doc/ms_timer.md
Name: ms_timer

Overview:
- Consumer of the millisecond tick (tick_ms = pulse_ms of the ms counter).
- Counts ms ticks against a programmed period and raises a one-cycle expiry pulse.
- One-shot or periodic mode.
- Used for exposure windows, frame intervals and watchdog timeouts in the ToF control path.

Parameters:
- PERIOD_W, 32, width of period_ms, remaining_ms and elapsed_ms.
- CNT_W, 16, width of expire_cnt.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on posedge clk).
- tick_ms  in  1  one-cycle ms strobe.
- start  in  1  one-cycle request: latch period_ms/periodic and (re)start.
- stop  in  1  one-cycle request: abort and return to IDLE.
- periodic  in  1  1 = auto-reload on expiry; 0 = one-shot. Sampled with start.
- period_ms  in  PERIOD_W  period in ms. Sampled with start.
- busy  out  1  1 while in RUN.
- expired  out  1  one-cycle pulse on each expiry.
- remaining_ms  out  PERIOD_W  ticks left in the current period.
- elapsed_ms  out  PERIOD_W  ticks since last start; wraps modulo 2^PERIOD_W.
- expire_cnt  out  CNT_W  expiries since last start; wraps.
- err  out  1  sticky: start issued with period_ms = 0. Cleared by the next valid start or by reset.

Behaviour:
- Reset (rst = 0): state IDLE. All outputs 0, including busy, expired, remaining_ms, elapsed_ms, expire_cnt, err. Reset mid-RUN aborts with no expired pulse.
- States: IDLE, RUN. All outputs are registered.
- Per-cycle priority: reset > stop > start > tick.

IDLE:
- start with period_ms != 0 → RUN on the next edge.
  - remaining_ms = period_ms; latch periodic.
  - elapsed_ms = 0, expire_cnt = 0, err = 0.
- start with period_ms = 0 → stay IDLE; err = 1; no expired pulse.
- tick_ms is ignored.
- elapsed_ms, remaining_ms and expire_cnt hold their last values. remaining_ms is 0 after a natural one-shot expiry.

RUN:
- stop → IDLE.
  - busy = 0 next cycle; remaining_ms holds; no expired, even if tick_ms is asserted in the same cycle.
- start (without stop) → restart exactly as from IDLE; the coincident tick is discarded.
  - start with period_ms = 0 → IDLE, err = 1.
- tick_ms with remaining_ms > 1:
  - remaining_ms -= 1; elapsed_ms += 1.
- tick_ms with remaining_ms == 1 (expiry):
  - expired = 1 for exactly the next cycle; elapsed_ms += 1; expire_cnt += 1.
  - Periodic: remaining_ms = latched period; stay RUN. No gap and no extra tick: each period is exactly period ticks.
  - One-shot: remaining_ms = 0; → IDLE; busy = 0 in the same cycle that expired = 1.

Timing:
- A tick arriving in the start cycle is not counted. The first counted tick is the first one strictly after start.
- The first interval is therefore between (period−1) and period ms of wall time. This is inherent and accepted.
- period_ms and periodic changes during RUN have no effect until the next start.

Width and wrap rules:
- elapsed_ms and expire_cnt wrap silently at 2^W.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst = 0 for 3 cycles while driving start = 1, tick_ms = 1 → all outputs 0, state IDLE.
- One-shot: period_ms = 3, start, then ticks every 10 cycles → remaining_ms goes 3, 2, 1, 0.
  - expired pulses once, 1 cycle after the 3rd tick.
  - busy drops in that same cycle; expire_cnt = 1, elapsed_ms = 3.
  - Further ticks change nothing.
- Periodic: period_ms = 2, periodic = 1, 7 ticks → expired after ticks 2, 4 and 6.
  - expire_cnt = 3, elapsed_ms = 7, remaining_ms = 1, busy = 1.
- Collisions:
  - start and tick_ms in the same cycle → that tick is not counted.
  - stop and final tick in the same cycle → no expired pulse, busy = 0, remaining_ms = 1.
  - stop and start in the same cycle → IDLE.
- Restart mid-run: period_ms = 5, 2 ticks, then start with period_ms = 4 → remaining_ms = 4, elapsed_ms = 0, expire_cnt = 0; expiry after 4 further ticks.
- Zero period: start with period_ms = 0 from IDLE and from RUN → IDLE, err = 1, no expired pulse. A following start with period_ms = 1 clears err, and the next tick gives expired.
